// File: rtl/compare_logger_if.sv
// compare_logger_if: command, read-data and error-log signal bundle for compare_logger.
// Signal names carry the checker's own direction suffix (_i into the checker, _o out of it).
// slave = checker side, master = driver side (command source, memory read path, log consumer).
interface compare_logger_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  localparam int B = DATA_W / 8;

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [15:0]       cmd_words_i;
  logic [B-1:0]      cmd_start_mask_i;
  logic [B-1:0]      cmd_end_mask_i;
  logic [7:0]        cmd_ptrn_i;
  logic [1:0]        cmd_mode_i;

  logic              readdatavalid_i;
  logic [DATA_W-1:0] readdata_i;

  logic              err_valid_o;
  logic              err_ready_i;
  logic [ADDR_W-1:0] err_addr_o;
  logic [7:0]        err_data_o;
  logic [7:0]        exp_data_o;

  modport slave (
    input  cmd_valid_i, cmd_addr_i, cmd_words_i, cmd_start_mask_i, cmd_end_mask_i,
           cmd_ptrn_i, cmd_mode_i, readdatavalid_i, readdata_i, err_ready_i,
    output cmd_ready_o, err_valid_o, err_addr_o, err_data_o, exp_data_o
  );

  modport master (
    output cmd_valid_i, cmd_addr_i, cmd_words_i, cmd_start_mask_i, cmd_end_mask_i,
           cmd_ptrn_i, cmd_mode_i, readdatavalid_i, readdata_i, err_ready_i,
    input  cmd_ready_o, err_valid_o, err_addr_o, err_data_o, exp_data_o
  );
endinterface

// File: rtl/compare_logger.sv
// compare_logger_fifo: generic pointer FIFO with synchronous clear.
// Latency: write visible on dout_o the cycle after push; dout_o reads 0 while empty.
// Backpressure: caller pushes only when !full_o (or while popping) and pops only when !empty_o.
module compare_logger_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q == {~rd_q[AW], rd_q[AW-1:0]});
  assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Push into a full FIFO while popping writes the slot being vacated this cycle.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// compare_logger: checks read beats against a per-command byte pattern and logs the
// lowest mismatching enabled lane per bad beat. Latency: entry visible 2 cycles after beat.
// Backpressure: commands stall on full command FIFO; a full error log drops entries (err_ovf_o).
// Ports: clk_i, rst_i (async, active-high), start_test_i (clear log/status),
//   bus (slave: command, read data, error log), err_cnt_o, err_ovf_o, busy_o.
module compare_logger #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int ERR_DEPTH   = 8,
  parameter int ERR_CNT_W   = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_test_i,
  compare_logger_if.slave      bus,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 err_ovf_o,
  output logic                 busy_o
);
  localparam int B    = DATA_W / 8;
  localparam int BW   = $clog2(B);
  localparam int WA_W = ADDR_W - BW;

  typedef struct packed {
    logic [WA_W-1:0] wa;     // word address (current beat once active)
    logic [15:0]     words;  // beats remaining, including the current one
    logic [B-1:0]    smask;
    logic [B-1:0]    emask;
    logic [7:0]      ptrn;   // expected byte for the current beat
    logic [1:0]      mode;
  } cmd_t;

  typedef struct packed {
    logic active;
    logic first;
    cmd_t cmd;
  } chk_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic [7:0]        exp;
  } err_t;

  cmd_t cmd_in, cmd_head;
  logic cmd_full, cmd_empty, cmd_push, cmd_pop;
  chk_t st_q, st_d;
  logic stop_q;
  logic s1_err_q;
  err_t s1_ent_q, s1_d, err_head;
  logic err_full, err_empty, err_push_req, err_push, err_pop, err_drop;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic ovf_q, busy_q;

  logic         beat_fire, last_beat, load, beat_err;
  logic [B-1:0] en, mis;
  logic [BW-1:0] lane;
  logic [7:0]   rbyte, exp_nxt;
  logic         unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus.cmd_addr_i[BW-1:0];

  // Command queue; while stopped it is held clear and new commands are swallowed.
  assign cmd_in = {bus.cmd_addr_i[ADDR_W-1:BW], bus.cmd_words_i, bus.cmd_start_mask_i,
                   bus.cmd_end_mask_i, bus.cmd_ptrn_i, bus.cmd_mode_i};
  assign bus.cmd_ready_o = stop_q | ~cmd_full;
  assign cmd_push        = bus.cmd_valid_i & ~cmd_full & ~stop_q;

  compare_logger_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (stop_q),
    .push_i (cmd_push),
    .din_i  (cmd_in),
    .pop_i  (cmd_pop),
    .dout_o (cmd_head),
    .full_o (cmd_full),
    .empty_o(cmd_empty)
  );

  assign beat_fire = bus.readdatavalid_i & st_q.active & ~stop_q;
  assign last_beat = (st_q.cmd.words == 16'd1);
  // Next command loads on the last beat of the current one, so there is no bubble.
  assign load      = ~stop_q & ~cmd_empty & (~st_q.active | (beat_fire & last_beat));
  assign cmd_pop   = load;

  always_comb begin
    en = '1;
    if (st_q.first) en = en & st_q.cmd.smask;
    if (last_beat)  en = en & st_q.cmd.emask;
    mis   = '0;
    lane  = '0;
    rbyte = '0;
    for (int i = 0; i < B; i++) begin
      mis[i] = en[i] && (bus.readdata_i[8*i +: 8] != st_q.cmd.ptrn);
    end
    // Descending scan so the lowest mismatching lane wins.
    for (int i = B - 1; i >= 0; i--) begin
      if (mis[i]) begin
        lane  = BW'(i);
        rbyte = bus.readdata_i[8*i +: 8];
      end
    end
  end

  assign beat_err = beat_fire & (|mis);
  assign s1_d     = {st_q.cmd.wa, lane, rbyte, st_q.cmd.ptrn};

  always_comb begin
    case (st_q.cmd.mode)
      2'd1:    exp_nxt = {st_q.cmd.ptrn[6:0], st_q.cmd.ptrn[6] ^ st_q.cmd.ptrn[1] ^ st_q.cmd.ptrn[0]};
      2'd2:    exp_nxt = st_q.cmd.ptrn + 8'd1;
      default: exp_nxt = st_q.cmd.ptrn;
    endcase
  end

  always_comb begin
    st_d = st_q;
    if (stop_q) begin
      st_d.active = 1'b0;
    end else if (beat_fire && !last_beat) begin
      st_d.first     = 1'b0;
      st_d.cmd.words = st_q.cmd.words - 16'd1;
      st_d.cmd.wa    = st_q.cmd.wa + WA_W'(1);
      st_d.cmd.ptrn  = exp_nxt;
    end else if (load) begin
      st_d.active = 1'b1;
      st_d.first  = 1'b1;
      st_d.cmd    = cmd_head;
    end else if (beat_fire) begin
      st_d.active = 1'b0;
    end
  end

  // Error log: an entry coinciding with start_test_i is discarded with the clear.
  assign err_pop      = ~err_empty & bus.err_ready_i;
  assign err_push_req = s1_err_q & ~start_test_i;
  assign err_push     = err_push_req & (~err_full | err_pop);
  assign err_drop     = err_push_req & err_full & ~err_pop;

  compare_logger_fifo #(.W($bits(err_t)), .DEPTH(ERR_DEPTH)) u_err_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (start_test_i),
    .push_i (err_push),
    .din_i  (s1_ent_q),
    .pop_i  (err_pop),
    .dout_o (err_head),
    .full_o (err_full),
    .empty_o(err_empty)
  );

  assign bus.err_valid_o = ~err_empty;
  assign bus.err_addr_o  = err_head.addr;
  assign bus.err_data_o  = err_head.data;
  assign bus.exp_data_o  = err_head.exp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q      <= '0;
      stop_q    <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_ent_q  <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      s1_err_q <= beat_err;
      if (beat_err) s1_ent_q <= s1_d;
      // Tracks the next-cycle state so busy drops right after the final beat.
      busy_q <= ~stop_q & (st_d.active | ~cmd_empty);
      if (start_test_i) begin
        stop_q    <= 1'b0;
        err_cnt_q <= '0;
        ovf_q     <= 1'b0;
      end else begin
        // Stop at detection so the beat right behind the first error is already ignored.
        if (STOP_ON_ERR && beat_err) stop_q <= 1'b1;
        if (s1_err_q && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        if (err_drop) ovf_q <= 1'b1;
      end
    end
  end

  assign err_cnt_o = err_cnt_q;
  assign err_ovf_o = ovf_q;
  assign busy_o    = busy_q;
endmodule

// File: tb/tb_compare_logger.sv
// tb_compare_logger: directed bench for compare_logger.
// Instance 0 runs with STOP_ON_ERR=0, instance 1 with STOP_ON_ERR=1.
// Expected values are hand-computed constants per vector.
module tb_compare_logger;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [1:0]        start_test, cmd_valid, rdv, err_ready;
  logic [ADDR_W-1:0] c_addr;
  logic [15:0]       c_words;
  logic [7:0]        c_smask, c_emask, c_ptrn;
  logic [1:0]        c_mode;
  logic [63:0]       rdata;

  logic [1:0]  cmd_ready, err_valid, err_ovf, busy;
  logic [31:0] err_addr [2];
  logic [7:0]  err_data [2];
  logic [7:0]  exp_data [2];
  logic [15:0] err_cnt  [2];

  int n_chk = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    compare_logger_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    assign bus.cmd_valid_i      = cmd_valid[g];
    assign bus.cmd_addr_i       = c_addr;
    assign bus.cmd_words_i      = c_words;
    assign bus.cmd_start_mask_i = c_smask;
    assign bus.cmd_end_mask_i   = c_emask;
    assign bus.cmd_ptrn_i       = c_ptrn;
    assign bus.cmd_mode_i       = c_mode;
    assign bus.readdatavalid_i  = rdv[g];
    assign bus.readdata_i       = rdata;
    assign bus.err_ready_i      = err_ready[g];
    assign cmd_ready[g]         = bus.cmd_ready_o;
    assign err_valid[g]         = bus.err_valid_o;
    assign err_addr[g]          = bus.err_addr_o;
    assign err_data[g]          = bus.err_data_o;
    assign exp_data[g]          = bus.exp_data_o;

    compare_logger #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .CMD_DEPTH  (4),
      .ERR_DEPTH  (8),
      .ERR_CNT_W  (16),
      .STOP_ON_ERR(g == 1)
    ) u_dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_test_i(start_test[g]),
      .bus         (bus),
      .err_cnt_o   (err_cnt[g]),
      .err_ovf_o   (err_ovf[g]),
      .busy_o      (busy[g])
    );
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input int d, input logic [31:0] a, input logic [15:0] w,
                          input logic [7:0] sm, input logic [7:0] em,
                          input logic [7:0] p, input logic [1:0] m);
    int n = 0;
    c_addr = a; c_words = w; c_smask = sm; c_emask = em; c_ptrn = p; c_mode = m;
    cmd_valid[d] = 1'b1;
    while (!cmd_ready[d] && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready", cmd_ready[d], 1);
    tick();
    cmd_valid[d] = 1'b0;
  endtask

  task automatic beat(input int d, input logic [63:0] data);
    rdv[d] = 1'b1;
    rdata  = data;
    tick();
    rdv[d] = 1'b0;
  endtask

  task automatic pop(input int d);
    err_ready[d] = 1'b1;
    tick();
    err_ready[d] = 1'b0;
  endtask

  task automatic clr(input int d);
    start_test[d] = 1'b1;
    tick();
    start_test[d] = 1'b0;
  endtask

  task automatic drain(input int d, output int n, output logic [31:0] last);
    n = 0;
    last = '0;
    while (err_valid[d] && n < 20) begin
      last = err_addr[d];
      pop(d);
      n++;
    end
  endtask

  initial begin
    int          n_ent;
    logic [31:0] last_a;
    start_test = '0; cmd_valid = '0; rdv = '0; err_ready = '0;
    c_addr = '0; c_words = '0; c_smask = '0; c_emask = '0; c_ptrn = '0; c_mode = '0;
    rdata = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    tick();

    // Reset state
    chk("rst_cmd_ready", cmd_ready[0], 1);
    chk("rst_err_valid", err_valid[0], 0);
    chk("rst_err_cnt",   err_cnt[0],   0);
    chk("rst_ovf",       err_ovf[0],   0);
    chk("rst_busy",      busy[0],      0);
    chk("rst_err_addr",  err_addr[0],  0);
    chk("rst_err_data",  err_data[0],  0);
    chk("rst_exp_data",  exp_data[0],  0);

    // Beats with no command loaded are ignored
    beat(0, 64'h0);
    tick(); tick();
    chk("idle_cnt",   err_cnt[0],   0);
    chk("idle_valid", err_valid[0], 0);

    // Clean fixed-pattern run
    send_cmd(0, 32'h100, 16'd4, 8'hFF, 8'hFF, 8'hA5, 2'd0);
    tick();
    chk("clean_busy", busy[0], 1);
    for (int i = 0; i < 4; i++) beat(0, {8{8'hA5}});
    chk("clean_busy_fall", busy[0], 0);
    tick(); tick();
    chk("clean_cnt",   err_cnt[0],   0);
    chk("clean_valid", err_valid[0], 0);

    // LFSR mismatch on beat 2, lane 5
    send_cmd(0, 32'h100, 16'd3, 8'hFF, 8'hFF, 8'h01, 2'd1);
    tick();
    beat(0, {8{8'h01}});
    beat(0, 64'h0303_0003_0303_0303);
    chk("lfsr_not_yet", err_valid[0], 0);
    beat(0, {8{8'h06}});
    chk("lfsr_valid", err_valid[0], 1);
    chk("lfsr_addr",  err_addr[0],  32'h10D);
    chk("lfsr_data",  err_data[0],  8'h00);
    chk("lfsr_exp",   exp_data[0],  8'h03);
    tick(); tick();
    chk("lfsr_cnt", err_cnt[0], 1);
    pop(0);
    chk("lfsr_popped", err_valid[0], 0);

    // Single-beat masking: only lanes 4..5 enabled
    send_cmd(0, 32'h200, 16'd1, 8'hF0, 8'h3C, 8'h5A, 2'd0);
    tick();
    beat(0, 64'hFFFF_5A5A_FFFF_FFFF);
    tick(); tick();
    chk("mask_clean_cnt",   err_cnt[0],   1);
    chk("mask_clean_valid", err_valid[0], 0);
    send_cmd(0, 32'h200, 16'd1, 8'hF0, 8'h3C, 8'h5A, 2'd0);
    tick();
    beat(0, 64'hFFFF_5A00_FFFF_FFFF);
    tick();
    chk("mask_err_valid", err_valid[0], 1);
    chk("mask_err_addr",  err_addr[0],  32'h204);
    chk("mask_err_data",  err_data[0],  8'h00);
    chk("mask_err_exp",   exp_data[0],  8'h5A);
    chk("mask_err_cnt",   err_cnt[0],   2);
    pop(0);
    clr(0);
    chk("clr_cnt", err_cnt[0], 0);

    // Back-to-back commands, increment mode, pattern restart on beat 3
    send_cmd(0, 32'h300, 16'd2, 8'h0F, 8'hF0, 8'h10, 2'd2);
    send_cmd(0, 32'h400, 16'd1, 8'h3C, 8'hFF, 8'h80, 2'd2);
    beat(0, 64'hEEEE_EEEE_1010_1010);
    beat(0, 64'h1111_1111_EEEE_EEEE);
    beat(0, 64'hEEEE_8080_8180_EEEE);
    tick();
    chk("b2b_valid", err_valid[0], 1);
    chk("b2b_addr",  err_addr[0],  32'h403);
    chk("b2b_data",  err_data[0],  8'h81);
    chk("b2b_exp",   exp_data[0],  8'h80);
    chk("b2b_cnt",   err_cnt[0],   1);
    chk("b2b_busy",  busy[0],      0);
    pop(0);
    chk("b2b_single", err_valid[0], 0);

    // Overflow: 10 errors into an 8-deep log with no pops
    clr(0);
    send_cmd(0, 32'h0, 16'd10, 8'hFF, 8'hFF, 8'h00, 2'd0);
    tick();
    for (int i = 0; i < 10; i++) beat(0, {8{8'hFF}});
    tick(); tick();
    chk("ovf_cnt",       err_cnt[0],   10);
    chk("ovf_flag",      err_ovf[0],   1);
    chk("ovf_head_addr", err_addr[0],  32'h0);
    chk("ovf_head_data", err_data[0],  8'hFF);
    drain(0, n_ent, last_a);
    chk("ovf_entries",   n_ent,        8);
    chk("ovf_last_addr", last_a,       32'h38);
    chk("ovf_sticky",    err_ovf[0],   1);
    clr(0);
    chk("ovf_clr_cnt",   err_cnt[0],   0);
    chk("ovf_clr_flag",  err_ovf[0],   0);

    // Push and pop together on a full log: nothing dropped; then clear with entries held
    send_cmd(0, 32'h0, 16'd9, 8'hFF, 8'hFF, 8'h00, 2'd0);
    tick();
    for (int i = 0; i < 9; i++) beat(0, {8{8'hFF}});
    err_ready[0] = 1'b1;
    tick();
    err_ready[0] = 1'b0;
    tick();
    chk("full_pp_ovf",  err_ovf[0],  0);
    chk("full_pp_cnt",  err_cnt[0],  9);
    chk("full_pp_head", err_addr[0], 32'h8);
    clr(0);
    chk("clr_valid", err_valid[0], 0);
    chk("clr_cnt2",  err_cnt[0],   0);
    chk("clr_ovf",   err_ovf[0],   0);

    // STOP_ON_ERR instance: first error halts checking
    send_cmd(1, 32'h500, 16'd2, 8'hFF, 8'hFF, 8'h55, 2'd0);
    send_cmd(1, 32'h600, 16'd1, 8'hFF, 8'hFF, 8'h55, 2'd0);
    beat(1, 64'h5555_5555_5500_5555);
    beat(1, 64'h0);
    beat(1, 64'h0);
    chk("stop_valid", err_valid[1], 1);
    chk("stop_addr",  err_addr[1],  32'h502);
    chk("stop_data",  err_data[1],  8'h00);
    chk("stop_exp",   exp_data[1],  8'h55);
    chk("stop_cnt",   err_cnt[1],   1);
    chk("stop_busy",  busy[1],      0);
    send_cmd(1, 32'h700, 16'd1, 8'hFF, 8'hFF, 8'h55, 2'd0);
    tick(); tick();
    chk("stop_discard_busy", busy[1], 0);
    beat(1, 64'h0);
    tick(); tick();
    chk("stop_ignore_cnt", err_cnt[1], 1);
    pop(1);
    chk("stop_one_entry", err_valid[1], 0);
    clr(1);
    send_cmd(1, 32'h800, 16'd1, 8'hFF, 8'hFF, 8'h55, 2'd0);
    tick();
    beat(1, 64'h0);
    tick();
    chk("restart_valid", err_valid[1], 1);
    chk("restart_addr",  err_addr[1],  32'h800);
    chk("restart_cnt",   err_cnt[1],   1);

    // Reset in the middle of a command abandons it
    send_cmd(0, 32'h100, 16'd4, 8'hFF, 8'hFF, 8'hA5, 2'd0);
    tick();
    beat(0, {8{8'hA5}});
    rst_i = 1'b1;
    #2;
    chk("midrst_busy",  busy[0],      0);
    chk("midrst_ready", cmd_ready[0], 1);
    rst_i = 1'b0;
    tick();
    beat(0, 64'h0);
    tick(); tick();
    chk("midrst_cnt",   err_cnt[0],   0);
    chk("midrst_valid", err_valid[0], 0);
    chk("midrst_idle",  busy[0],      0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/compare_logger.md
COMPARE_LOGGER -- requirements
Module: compare_logger

Interface
REQ-001 SHALL have parameter DATA_W, default 64: read data width in bits, a multiple of 8; B = DATA_W/8 byte lanes.
REQ-002 SHALL have parameter ADDR_W, default 32: byte address width; BW = clog2(B).
REQ-003 SHALL have parameter CMD_DEPTH, default 4: command FIFO depth, a power of 2 and at least 2.
REQ-004 SHALL have parameter ERR_DEPTH, default 8: error log FIFO depth, a power of 2 and at least 2.
REQ-005 SHALL have parameter ERR_CNT_W, default 16: error counter width.
REQ-006 SHALL have parameter STOP_ON_ERR, default 0: when 1, checking halts after the first error.
REQ-007 SHALL have port clk_i, input, 1 bit: clock.
REQ-008 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have port start_test_i, input, 1 bit: single-cycle test start / clear.
REQ-010 SHALL have the following command ports:
- cmd_valid_i, input, 1 bit; cmd_ready_o, output, 1 bit: valid/ready command handshake.
- cmd_addr_i, input, ADDR_W bits: byte address of the first word; the low BW bits are ignored.
- cmd_words_i, input, 16 bits: beat count, 1..65535; 0 is illegal.
- cmd_start_mask_i and cmd_end_mask_i, input, B bits each: byte-enable masks for the first and last beat.
- cmd_ptrn_i, input, 8 bits: initial expected byte.
- cmd_mode_i, input, 2 bits: 0 = fixed, 1 = LFSR, 2 = increment, 3 = treated as fixed.
REQ-011 SHALL have the following read data ports:
- readdatavalid_i, input, 1 bit.
- readdata_i, input, DATA_W bits.
REQ-012 SHALL have the following error log ports:
- err_valid_o, output, 1 bit; err_ready_i, input, 1 bit: valid/ready pop handshake.
- err_addr_o, output, ADDR_W bits.
- err_data_o, output, 8 bits.
- exp_data_o, output, 8 bits.
REQ-013 SHALL have the following status ports:
- err_cnt_o, output, ERR_CNT_W bits.
- err_ovf_o, output, 1 bit.
- busy_o, output, 1 bit.

Function
REQ-014 SHALL accept a command on a cycle with cmd_valid_i=1 and cmd_ready_o=1; cmd_ready_o=1 exactly when the command FIFO is not full.
REQ-015 SHALL load the head command into the checker when the checker is idle, or in the same cycle the last beat of the current command is checked, so commands run back-to-back with zero bubble.
REQ-016 SHALL ignore readdatavalid_i while no command is active: no count, no error.
REQ-017 SHALL use these per-beat byte-enable masks:
- beat 1 of N>1: start mask;
- beat N of N>1: end mask;
- middle beats: all ones;
- N=1: start AND end.
REQ-018 SHALL use one expected byte E for all lanes of a beat, starting at cmd_ptrn_i; after each beat E updates by mode:
- fixed: unchanged;
- LFSR: E = {E[6:0], E[6]^E[1]^E[0]};
- increment: E = E+1 mod 256.
REQ-019 SHALL flag a beat as erroneous when any enabled lane differs from E; the reported lane L is the lowest-index mismatching enabled lane.
REQ-020 SHALL build the error entry as follows:
- err_addr_o = {word_addr, L[BW-1:0]}, where word_addr = cmd word address plus beat index, wrapping mod 2^(ADDR_W-BW);
- err_data_o = the read byte of lane L;
- exp_data_o = E.
REQ-021 SHALL push the error entry into the error FIFO 2 cycles after the beat's readdatavalid_i, sustaining 1 beat/cycle.
REQ-022 SHALL drop an error entry that finds the error FIFO full, and set err_ovf_o, which is sticky until start_test_i.
REQ-023 SHALL increment err_cnt_o per erroneous beat, including dropped ones, saturating at all-ones.
REQ-024 SHALL present the error FIFO head on err_valid_o/err_addr_o/err_data_o/exp_data_o and pop it on err_valid_o=1 and err_ready_i=1; a simultaneous push and pop on a full FIFO SHALL NOT drop the entry.
REQ-025 SHALL, when STOP_ON_ERR=1, set an internal stop flag on the first logged error; while the flag is set the block SHALL:
- discard queued and active commands;
- ignore beats;
- keep cmd_ready_o=1 and discard new commands.
REQ-026 SHALL, on start_test_i, in the next cycle:
- clear err_cnt_o, err_ovf_o, the stop flag and the error FIFO;
- leave the command FIFO and the active command intact.
An error pushed in the same cycle as start_test_i SHALL be discarded.
REQ-027 SHALL register busy_o = (command FIFO not empty) OR (command active), with one cycle of latency.

Reset
REQ-028 SHALL reset asynchronously on rst_i=1 to the following state:
- both FIFOs empty;
- checker idle;
- stop flag = 0;
- cmd_ready_o = 1;
- err_valid_o = 0, err_cnt_o = 0, err_ovf_o = 0, busy_o = 0;
- err_addr_o, err_data_o and exp_data_o = 0.
REQ-029 SHALL abandon any active command on reset mid-operation; beats arriving after reset release with no command loaded SHALL be ignored.

Verification
REQ-030 SHALL cover a clean run: DATA_W=64, cmd addr 0x100, 4 words, masks 0xFF, mode fixed, ptrn 0xA5, all bytes 0xA5 -> err_cnt_o=0, err_valid_o=0, busy_o falls 1 cycle after the last beat.
REQ-031 SHALL cover an LFSR mismatch: ptrn 0x01, mode LFSR, 3 words, beat 2 (E=0x03) has lane 5 = 0x00 -> one entry err_addr_o=0x10D (cmd addr 0x100), err_data_o=0x00, exp_data_o=0x03, err_valid_o 2 cycles after the beat.
REQ-032 SHALL cover masking: 1 word, start mask 0xF0, end mask 0x3C, lanes 0..3 and 6..7 corrupt -> no error; corrupt lane 4 -> error with L=4.
REQ-033 SHALL cover overflow: ERR_DEPTH=8, err_ready_i=0, 10 erroneous beats -> 8 entries, err_ovf_o=1, err_cnt_o=10; then start_test_i -> err_valid_o=0, err_cnt_o=0, err_ovf_o=0.
REQ-034 SHALL cover back-to-back commands: two queued commands (2 and 1 words), continuous readdatavalid_i -> correct masks and pattern restart on beat 3; with STOP_ON_ERR=1 and an error on beat 1 -> exactly one entry, remaining beats ignored, busy_o=0.
